// File: rtl/mult_stage_sequencer_pkg.sv
// Shared definitions for the GF(2) multiply stage sequencer: FSM state encoding
// and default message/circulant widths.
package mult_stage_sequencer_pkg;

  localparam int DEFAULT_K = 16;
  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mult_stage_sequencer_gf2_mac_stage.sv
// One GF(2) multiply-accumulate lane: conditionally XOR the current circulant
// row into the accumulator when the message bit is set.
module gf2_mac_stage #(
  parameter int W = 8
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] row,
  input  logic         msg_bit,
  output logic [W-1:0] acc_next
);

  assign acc_next = acc ^ (row & {W{msg_bit}});

endmodule

// File: rtl/mult_stage_sequencer.sv
// Bit-serial GF(2) message x circulant sequencer, one message bit per cycle.
// Optional build macro MULT_SEQ_EARLY_EXIT_EN ends RUN once the remaining message bits are zero.
//
// state | meaning
// IDLE  | waiting for a message/seed, in_ready high
// RUN   | one AND-XOR step per cycle, row rotates left, counter advances
// DONE  | parity held with out_valid until the consumer takes it
module mult_stage_sequencer
  import mult_stage_sequencer_pkg::*;
#(
  parameter int K = DEFAULT_K,
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] msg,
  input  logic [W-1:0] seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] parity,
  output logic         busy
);

  localparam int CW = $clog2(K + 1);

  seq_state_t     state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   row;
  logic [W-1:0]   acc;
  logic [W-1:0]   acc_next;
  logic [K-1:0]   msg_sh;
  logic           run_exit;

  gf2_mac_stage #(.W(W)) u_mac (
    .acc      (acc),
    .row      (row),
    .msg_bit  (msg_sh[0]),
    .acc_next (acc_next)
  );

  // The exit test runs before the step's update, so DONE lands one cycle
  // after the last real step; K steps therefore give out_valid at K+1.
`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign run_exit = (cnt == CW'(K)) || (msg_sh == '0);
`else
  assign run_exit = (cnt == CW'(K));
`endif

  assign parity = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      row       <= '0;
      msg_sh    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            msg_sh   <= msg;
            row      <= seed;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_exit) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            acc    <= acc_next;
            row    <= {row[W-2:0], row[W-1]};
            msg_sh <= msg_sh >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
